// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and requester indices for the register-file write arbiter.
package regfile_write_arbiter_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int NUM_REGS_DEF   = 8;
    localparam int NUM_REQ        = 2;
    localparam int REQ_ALU        = 0;
    localparam int REQ_LOAD       = 1;
endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// Single-entry writeback holding buffer with an age bit that records whether
// this entry was captured before the entry held by the other requester.
module wb_hold_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic                  drain,
    input  logic                  other_capture,
    input  logic                  other_full_next,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  older
);
    logic survive;
    assign survive = full && !drain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 1'b0;
            addr  <= '0;
            data  <= '0;
            older <= 1'b0;
        end else begin
            if (capture) begin
                addr <= in_addr;
                data <= in_data;
            end
            full  <= capture || survive;
            // Age is only meaningful while both entries are occupied; it is set
            // when the other side captures behind a surviving entry.
            older <= survive && other_full_next && (older || other_capture);
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the ALU and load
// writeback paths, and publishes a pending-write scoreboard and read stall.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_inaddress,
    output logic [DATA_WIDTH-1:0] rf_in,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    input  logic [ADDR_WIDTH-1:0] rd2_addr,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  stall
);
    if (NUM_REGS != 2 ** ADDR_WIDTH) begin : g_bad_cfg
        $error("NUM_REGS must equal 2**ADDR_WIDTH");
    end

    logic [NUM_REQ-1:0]                 valid, ready, acc, full, older, grant, full_next;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] in_addr, addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] in_data, data;
    logic                               rr, rr_flip;

    assign valid[REQ_ALU]    = req0_valid;
    assign valid[REQ_LOAD]   = req1_valid;
    assign in_addr[REQ_ALU]  = req0_addr;
    assign in_addr[REQ_LOAD] = req1_addr;
    assign in_data[REQ_ALU]  = req0_data;
    assign in_data[REQ_LOAD] = req1_data;
    assign req0_ready        = ready[REQ_ALU];
    assign req1_ready        = ready[REQ_LOAD];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_buf
        localparam int O = NUM_REQ - 1 - i;
        // Ready is forced low while reset is held so nothing is accepted then.
        assign ready[i]     = reset && (!full[i] || grant[i]);
        assign acc[i]       = valid[i] && ready[i];
        assign full_next[i] = acc[i] || (full[i] && !grant[i]);

        wb_hold_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_buf (
            .clk            (clk),
            .reset          (reset),
            .capture        (acc[i]),
            .drain          (grant[i]),
            .other_capture  (acc[O]),
            .other_full_next(full_next[O]),
            .in_addr        (in_addr[i]),
            .in_data        (in_data[i]),
            .full           (full[i]),
            .addr           (addr[i]),
            .data           (data[i]),
            .older          (older[i])
        );
    end

    // Same-address ties always go ALU first so the load value lands last.
    always_comb begin
        grant   = '0;
        rr_flip = 1'b0;
        case (full)
            2'b01: grant[REQ_ALU]  = 1'b1;
            2'b10: grant[REQ_LOAD] = 1'b1;
            2'b11: begin
                if (older[REQ_ALU])
                    grant[REQ_ALU] = 1'b1;
                else if (older[REQ_LOAD])
                    grant[REQ_LOAD] = 1'b1;
                else if (addr[REQ_ALU] != addr[REQ_LOAD]) begin
                    grant[REQ_LOAD] = rr;
                    grant[REQ_ALU]  = !rr;
                    rr_flip         = 1'b1;
                end else
                    grant[REQ_ALU] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr <= 1'b0;
        else if (rr_flip)
            rr <= !rr;
    end

    assign rf_write     = |grant;
    assign rf_inaddress = grant[REQ_LOAD] ? addr[REQ_LOAD] :
                          grant[REQ_ALU]  ? addr[REQ_ALU]  : '0;
    assign rf_in        = grant[REQ_LOAD] ? data[REQ_LOAD] :
                          grant[REQ_ALU]  ? data[REQ_ALU]  : '0;

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (full[REQ_ALU]  && addr[REQ_ALU]  == ADDR_WIDTH'(r)) ||
                      (full[REQ_LOAD] && addr[REQ_LOAD] == ADDR_WIDTH'(r));
        end
    end

    assign stall = busy[rd1_addr] || busy[rd2_addr];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench: expected register-file writes are queued by the
// stimulus and popped by an independent monitor whenever the write port fires.
module tb_regfile_write_arbiter;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, rf_inaddress, rd1_addr, rd2_addr;
    logic [DW-1:0] req0_data, req1_data, rf_in;
    logic          rf_write, stall;
    logic [NR-1:0] busy;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    rf_model[NR];
    int               checks = 0;
    int               errors = 0;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_write(rf_write), .rf_inaddress(rf_inaddress), .rf_in(rf_in),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < NR; i++) rf_model[i] = '0;
    always @(posedge clk) if (rf_write) rf_model[rf_inaddress] <= rf_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write-port cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rf_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected none at %0t",
                         rf_inaddress, rf_in, $time);
            end else begin
                chk("wr_order", {rf_inaddress, rf_in}, exp_q.pop_front());
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Called just after a posedge; returns just after the edge that accepted
    // the last outstanding request.
    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic r0, r1;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        for (int n = 0; n < 20 && (req0_valid || req1_valid); n++) begin
            @(negedge clk);
            r0 = req0_ready;
            r1 = req1_ready;
            @(posedge clk); #1;
            if (r0) req0_valid = 1'b0;
            if (r1) req1_valid = 1'b0;
        end
        if (req0_valid || req1_valid) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got valid %b%b expected 00", req1_valid, req0_valid);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'd99;
        req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
        rd1_addr = 3'd0; rd2_addr = 3'd7;

        repeat (3) begin
            @(negedge clk);
            chk("rst_write", rf_write, 1'b0);
            chk("rst_addr", rf_inaddress, 3'd0);
            chk("rst_busy", busy, 8'h00);
            chk("rst_ready0", req0_ready, 1'b0);
            chk("rst_ready1", req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready0", req0_ready, 1'b1);
        chk("rel_ready1", req1_ready, 1'b1);
        chk("rel_stall", stall, 1'b0);
        @(posedge clk); #1;

        // Single uncontended write: visible on the port in the cycle after accept.
        push(3'd2, 8'd95);
        drive(1'b1, 3'd2, 8'd95, 1'b0, 3'd0, 8'd0);
        @(negedge clk);
        chk("single_write", rf_write, 1'b1);
        chk("single_addr", rf_inaddress, 3'd2);
        chk("single_data", rf_in, 8'd95);
        chk("single_busy", busy, 8'h04);
        @(posedge clk); #1;
        chk("single_busy_clr", busy, 8'h00);
        chk("single_reg2", rf_model[2], 8'd95);

        // Same-age pair, different addresses: pointer starts at ALU.
        rd1_addr = 3'd4;
        push(3'd1, 8'd28);
        push(3'd4, 8'd6);
        drive(1'b1, 3'd1, 8'd28, 1'b1, 3'd4, 8'd6);
        @(negedge clk);
        chk("pair_ready1_low", req1_ready, 1'b0);
        chk("pair_ready0", req0_ready, 1'b1);
        chk("pair_busy", busy, 8'h12);
        chk("pair_stall", stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pair_ready1_back", req1_ready, 1'b1);
        chk("pair_stall_hold", stall, 1'b1);
        chk("pair_busy2", busy, 8'h10);
        @(posedge clk); #1;
        chk("pair_stall_clr", stall, 1'b0);
        rd1_addr = 3'd0;

        // Second pair: pointer has moved to the load requester.
        push(3'd6, 8'd44);
        push(3'd2, 8'd33);
        drive(1'b1, 3'd2, 8'd33, 1'b1, 3'd6, 8'd44);
        idle(3);

        // Same address: ALU first, load value is final; pointer unchanged.
        rd2_addr = 3'd3;
        push(3'd3, 8'd10);
        push(3'd3, 8'd50);
        drive(1'b1, 3'd3, 8'd10, 1'b1, 3'd3, 8'd50);
        @(negedge clk);
        chk("same_stall_rd2", stall, 1'b1);
        idle(3);
        chk("same_reg3", rf_model[3], 8'd50);
        rd2_addr = 3'd7;

        // Age: load (5,7) waits behind the ALU grant; new ALU (6,9) must not pass it.
        push(3'd5, 8'd1);
        push(3'd5, 8'd7);
        push(3'd6, 8'd9);
        drive(1'b1, 3'd5, 8'd1, 1'b1, 3'd5, 8'd7);
        drive(1'b1, 3'd6, 8'd9, 1'b0, 3'd0, 8'd0);
        chk("age_busy", busy, 8'h60);
        idle(3);
        chk("age_reg5", rf_model[5], 8'd7);
        chk("age_reg6", rf_model[6], 8'd9);

        // Reset with both buffers full: the pending writes are discarded.
        drive(1'b1, 3'd0, 8'd77, 1'b1, 3'd7, 8'd88);
        chk("prerst_busy", busy, 8'h81);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_write", rf_write, 1'b0);
        chk("midrst_busy", busy, 8'h00);
        chk("midrst_ready0", req0_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(3);
        chk("midrst_reg0", rf_model[0], 8'd0);
        chk("midrst_reg7", rf_model[7], 8'd0);
        chk("final_reg1", rf_model[1], 8'd28);
        chk("final_reg4", rf_model[4], 8'd6);
        chk("final_reg2", rf_model[2], 8'd33);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU result (REQ0) and data-memory load (REQ1).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Buffered writes drain onto the register file's write port, one per clock.
- Publishes a per-register pending-write scoreboard and a read-hazard STALL for the control unit.

Parameters:
- DATA_WIDTH, 8, width of write data.
- ADDR_WIDTH, 3, register address width.
- NUM_REGS, 8, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0_VALID  in  1  ALU writeback request.
- REQ0_ADDR  in  ADDR_WIDTH  destination register of REQ0.
- REQ0_DATA  in  DATA_WIDTH  write value of REQ0.
- REQ0_READY  out  1  REQ0 buffer can accept this cycle.
- REQ1_VALID, REQ1_ADDR, REQ1_DATA, REQ1_READY  in/in/in/out  1/ADDR_WIDTH/DATA_WIDTH/1  same as REQ0, for the load unit.
- RF_WRITE  out  1  write enable to the register file.
- RF_INADDRESS  out  ADDR_WIDTH  write address to the register file.
- RF_IN  out  DATA_WIDTH  write data to the register file.
- RD1_ADDR, RD2_ADDR  in  ADDR_WIDTH each  read addresses currently presented to the register file.
- BUSY  out  NUM_REGS  bit r set while a buffered write to register r is pending.
- STALL  out  1  a read address hits a busy register.

Behaviour:
- Reset (RESET low, asynchronous): both buffers empty, age flags cleared, round-robin pointer = 0. Outputs while low: RF_WRITE=0, RF_INADDRESS=0, RF_IN=0, BUSY=0, STALL=0, REQ0_READY=0, REQ1_READY=0.
- Reset release: READY rises combinationally and is 1 in the first cycle after release.
- Buffer n state: FULLn, ADDRn, DATAn, OLDERn.
  - OLDERn = 1 when entry n was captured on an earlier edge than the other full entry.
- Accept: on posedge, if REQn_VALID && REQn_READY, capture ADDR/DATA and set FULLn.
- REQn_READY = !FULLn || GRANTn (a granted buffer is refilled on the same edge; full throughput is 1 write/cycle/requester when uncontended).
- Grant (combinational, from buffer state only; requests are never bypassed):
  - Only one buffer full: grant it.
  - Both full, one OLDER: grant the older.
  - Both full, same age, different addresses: grant the requester selected by the RR pointer. The pointer flips to the other requester after each such grant.
  - Both full, same age, same address: grant REQ0 first, then REQ1, so REQ1's value is final. The RR pointer is not changed.
- Granted entry drives RF_WRITE=1, RF_INADDRESS=ADDRn, RF_IN=DATAn. The register file captures it at the next posedge, and FULLn clears on that edge unless it is refilled.
- Latency: request accepted at edge k, written to the register file at edge k+1 when uncontended. A contended entry waits at most one extra cycle.
- Age update: when one buffer is full and the other is captured, the surviving entry's OLDER bit is set. Both OLDER bits clear when either buffer empties.
- BUSY[r] = (FULL0 && ADDR0==r) || (FULL1 && ADDR1==r).
- STALL = BUSY[RD1_ADDR] || BUSY[RD2_ADDR]. Combinational, with no bypass of buffered data.
- Reset mid-operation: pending buffered writes are discarded and never reach the register file. RF_WRITE drops immediately.
- VALID held with READY low: the requester must hold ADDR/DATA stable. No request is lost or duplicated.

Decomposition:
- Shared package holds DATA_WIDTH/ADDR_WIDTH/NUM_REGS defaults and the requester-index constants REQ_ALU=0, REQ_LOAD=1.
- One sub-module, wb_hold_buffer: a single-entry valid/ready buffer with FULL, ADDR, DATA and an age bit. It is instantiated twice.
- Grant logic, RR pointer and scoreboard stay in the top module.

Test Plan:
- Reset: hold RESET low 3 cycles with REQ0_VALID=1 -> RF_WRITE=0, BUSY=0, READY=0. Release -> READY=1 next cycle.
- Single write: REQ0 (addr 2, data 95) accepted at edge k -> RF_WRITE=1 with addr 2 / 95 during cycle k..k+1. BUSY[2]=1 in that cycle, then 0. Register 2 reads 95.
- Simultaneous, different addresses: REQ0 (1, 28) and REQ1 (4, 6) accepted the same edge -> REQ0 written first (pointer=0), REQ1 next cycle. REQ1_READY=0 for one cycle. A second such pair is granted REQ1 first.
- Simultaneous, same address: REQ0 (3, 10) and REQ1 (3, 50) -> two writes in order 10 then 50. Register 3 ends at 50.
- Age priority: REQ1 (5, 7) is waiting behind a grant when a new REQ0 (6, 9) arrives -> REQ1's older entry is granted before REQ0.
- Hazard and reset: while BUSY[4]=1, RD1_ADDR=4 -> STALL=1. Assert RESET with both buffers full -> no RF_WRITE occurs and register contents remain unchanged.
